// File: rtl/instruction_mem.sv
// Byte-addressed instruction store: combinational little-endian fetch, byte-strobed load port,
// synchronous reset to the diagnostic image mem[i] = i[7:0]. Optional macro: IMEM_MISALIGN_FAULT_EN.
module instruction_mem #(
  parameter int DEPTH_BYTES = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [63:0] ADDR,
  output logic [31:0] OUTPUT,
  output logic        FAULT,
  input  logic        WE,
  input  logic [63:0] WADDR,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB
);

  localparam int          AW      = $clog2(DEPTH_BYTES);
  localparam logic [63:0] DEPTH64 = 64'(DEPTH_BYTES);
  localparam logic [63:0] LAST_OK = DEPTH64 - 64'd4;

  logic [7:0]    mem_q [DEPTH_BYTES];
  logic          in_range_s;
  logic          fault_s;
  logic [AW-1:0] ridx_s;

  // Reset image load has priority; otherwise write enabled bytes that land inside the array.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH_BYTES; i++) begin
        mem_q[i] <= 8'(i);
      end
    end else if (WE) begin
      for (int k = 0; k < 4; k++) begin
        // Compare against DEPTH-k rather than WADDR+k so a huge WADDR cannot wrap into range.
        if (WSTRB[k] && (WADDR < (DEPTH64 - 64'(k)))) begin
          mem_q[AW'(WADDR + 64'(k))] <= WDATA[8*k +: 8];
        end
      end
    end
  end

  // Fetch path: full 64-bit range check, optional alignment check, gated little-endian read.
  always_comb begin
    in_range_s = (ADDR <= LAST_OK);
`ifdef IMEM_MISALIGN_FAULT_EN
    fault_s    = !in_range_s || (ADDR[1:0] != 2'b00);
`else
    fault_s    = !in_range_s;
`endif
    // Index is clamped to 0 when out of range so the read never leaves the array.
    if (in_range_s) begin
      ridx_s = ADDR[AW-1:0];
    end else begin
      ridx_s = '0;
    end
    OUTPUT = 32'h0000_0000;
    FAULT  = fault_s;
    if (!fault_s) begin
      for (int k = 0; k < 4; k++) begin
        OUTPUT[8*k +: 8] = mem_q[ridx_s + AW'(k)];
      end
    end else begin
      OUTPUT = 32'h0000_0000;
    end
  end

endmodule

// File: tb/tb_instruction_mem.sv
// Directed self-checking bench for instruction_mem (DEPTH_BYTES=1024).
module tb_instruction_mem;

  logic        CLK;
  logic        RST;
  logic [63:0] ADDR;
  logic [31:0] OUTPUT;
  logic        FAULT;
  logic        WE;
  logic [63:0] WADDR;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;

  int checks;
  int failures;

  instruction_mem #(.DEPTH_BYTES(1024)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .OUTPUT(OUTPUT), .FAULT(FAULT),
    .WE(WE), .WADDR(WADDR), .WDATA(WDATA), .WSTRB(WSTRB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_words [6];
    exp_words = '{32'h03020100, 32'h04030201, 32'h05040302,
                  32'h06050403, 32'h07060504, 32'h08070605};
    do_reset();
    for (int a = 0; a < 6; a++) begin
      ADDR = 64'(a);
      #1;
      checks++;
      if (OUTPUT !== exp_words[a]) begin
        $display("FAIL reset_sweep addr=%0d got=%h exp=%h", a, OUTPUT, exp_words[a]);
        failures++;
      end
      checks++;
      if (FAULT !== 1'b0) begin
        $display("FAIL reset_sweep_fault addr=%0d got=%b exp=0", a, FAULT);
        failures++;
      end
    end
  endtask

  task automatic test_full_write();
    ADDR  = 64'd0;
    WE    = 1'b1;
    WADDR = 64'd0;
    WDATA = 32'h0000_0013;
    WSTRB = 4'hF;
    #1;
    checks++;
    if (OUTPUT !== 32'h03020100) begin
      $display("FAIL full_write_before got=%h exp=03020100", OUTPUT);
      failures++;
    end
    tick();
    WE = 1'b0;
    #1;
    checks++;
    if (OUTPUT !== 32'h00000013) begin
      $display("FAIL full_write_after got=%h exp=00000013", OUTPUT);
      failures++;
    end
  endtask

  task automatic test_partial_write();
    do_reset();
    WE    = 1'b1;
    WADDR = 64'd8;
    WDATA = 32'hAABBCCDD;
    WSTRB = 4'b0101;
    tick();
    WE   = 1'b0;
    ADDR = 64'd8;
    #1;
    checks++;
    if (OUTPUT !== 32'h0BBB09DD) begin
      $display("FAIL partial_write got=%h exp=0BBB09DD", OUTPUT);
      failures++;
    end
  endtask

  task automatic test_range();
    logic [63:0] addrs  [3];
    logic [31:0] outs   [3];
    logic        faults [3];
    addrs  = '{64'd1020, 64'd1021, 64'hFFFF_FFFF_FFFF_FFFC};
    outs   = '{32'hFFFEFDFC, 32'h00000000, 32'h00000000};
    faults = '{1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ADDR = addrs[i];
      #1;
      checks++;
      if (OUTPUT !== outs[i]) begin
        $display("FAIL range_out addr=%h got=%h exp=%h", addrs[i], OUTPUT, outs[i]);
        failures++;
      end
      checks++;
      if (FAULT !== faults[i]) begin
        $display("FAIL range_fault addr=%h got=%b exp=%b", addrs[i], FAULT, faults[i]);
        failures++;
      end
    end
    // Straddling write at the top: bytes 1024/1025 must be dropped.
    WE    = 1'b1;
    WADDR = 64'd1022;
    WDATA = 32'h11223344;
    WSTRB = 4'hF;
    tick();
    // Huge address must not wrap onto bytes 0..1.
    WADDR = 64'hFFFF_FFFF_FFFF_FFFE;
    WDATA = 32'h55667788;
    tick();
    WE   = 1'b0;
    ADDR = 64'd1020;
    #1;
    checks++;
    if (OUTPUT !== 32'h3344FDFC) begin
      $display("FAIL range_top_write got=%h exp=3344FDFC", OUTPUT);
      failures++;
    end
    ADDR = 64'd0;
    #1;
    checks++;
    if (OUTPUT !== 32'h03020100) begin
      $display("FAIL range_no_wrap got=%h exp=03020100", OUTPUT);
      failures++;
    end
  endtask

  task automatic test_reset_vs_write();
    WE    = 1'b1;
    WADDR = 64'd4;
    WDATA = 32'hCAFEF00D;
    WSTRB = 4'hF;
    tick();
    ADDR = 64'd4;
    #1;
    checks++;
    if (OUTPUT !== 32'hCAFEF00D) begin
      $display("FAIL prewrite got=%h exp=CAFEF00D", OUTPUT);
      failures++;
    end
    RST   = 1'b1;
    WADDR = 64'd0;
    WDATA = 32'hDEADBEEF;
    tick();
    RST = 1'b0;
    WE  = 1'b0;
    ADDR = 64'd0;
    #1;
    checks++;
    if (OUTPUT !== 32'h03020100) begin
      $display("FAIL reset_vs_write got=%h exp=03020100", OUTPUT);
      failures++;
    end
    ADDR = 64'd4;
    #1;
    checks++;
    if (OUTPUT !== 32'h07060504) begin
      $display("FAIL reset_overwrites got=%h exp=07060504", OUTPUT);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    WE    = 1'b1;
    WSTRB = 4'hF;
    WADDR = 64'd16;
    WDATA = 32'h00500093;
    tick();
    WADDR = 64'd20;
    WDATA = 32'h00A00113;
    tick();
    WE   = 1'b0;
    ADDR = 64'd16;
    #1;
    checks++;
    if (OUTPUT !== 32'h00500093) begin
      $display("FAIL b2b_first got=%h exp=00500093", OUTPUT);
      failures++;
    end
    ADDR = 64'd20;
    #1;
    checks++;
    if (OUTPUT !== 32'h00A00113) begin
      $display("FAIL b2b_second got=%h exp=00A00113", OUTPUT);
      failures++;
    end
    ADDR = 64'd18;
    #1;
    checks++;
    if (OUTPUT !== 32'h01130050) begin
      $display("FAIL b2b_unaligned got=%h exp=01130050", OUTPUT);
      failures++;
    end
  endtask

  task automatic test_alignment();
    logic [31:0] exp6;
    logic        expf;
    do_reset();
    ADDR = 64'd4;
    #1;
    checks++;
    if (OUTPUT !== 32'h07060504 || FAULT !== 1'b0) begin
      $display("FAIL align4 got=%h/%b exp=07060504/0", OUTPUT, FAULT);
      failures++;
    end
`ifdef IMEM_MISALIGN_FAULT_EN
    exp6 = 32'h00000000;
    expf = 1'b1;
`else
    exp6 = 32'h09080706;
    expf = 1'b0;
`endif
    ADDR = 64'd6;
    #1;
    checks++;
    if (OUTPUT !== exp6 || FAULT !== expf) begin
      $display("FAIL align6 got=%h/%b exp=%h/%b", OUTPUT, FAULT, exp6, expf);
      failures++;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST   = 1'b1;
    ADDR  = 64'd0;
    WE    = 1'b0;
    WADDR = 64'd0;
    WDATA = 32'd0;
    WSTRB = 4'h0;
    test_reset();
    test_full_write();
    test_partial_write();
    test_range();
    test_reset_vs_write();
    test_back_to_back();
    test_alignment();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_mem.md
# instruction_mem

Byte-addressed instruction store for the RISC-V datapath. It returns the 32-bit instruction word starting at any byte address through a combinational fetch port and a little-endian byte order. A synchronous program-load port fills it, and a synchronous reset restores a fixed diagnostic image. It sits between the PC register and the instruction decoder.

## Interface
Parameters:
- DEPTH_BYTES, 1024: memory size in bytes; must be a multiple of 4 and at least 8.

Ports:
- CLK  in  1  clock; all state changes occur on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- ADDR  in  64  fetch byte address (PC).
- OUTPUT  out  32  instruction word; bytes mem[ADDR+3..ADDR], with mem[ADDR] in bits [7:0].
- FAULT  out  1  fetch fault for the current ADDR.
- WE  in  1  program-load write enable.
- WADDR  in  64  program-load byte address.
- WDATA  in  32  program-load data, little-endian.
- WSTRB  in  4  byte enables; WSTRB[k] enables the write of WDATA[8k+7:8k] to mem[WADDR+k].

## Operation
- Storage is DEPTH_BYTES bytes, mem[0..DEPTH_BYTES-1].
- Fetch is combinational. OUTPUT = {mem[ADDR+3], mem[ADDR+2], mem[ADDR+1], mem[ADDR]}.
- Fetch accepts any byte alignment, so ADDR=1 returns bytes 1..4.
- Range check: if ADDR > DEPTH_BYTES-4, compared using the full 64 bits:
  - FAULT=1 and OUTPUT=32'h0000_0000.
  - There is no wrap-around.
- Otherwise FAULT=0, subject to Configuration.
- Write: on a rising CLK edge with WE=1 and RST=0, each enabled byte k with WADDR+k < DEPTH_BYTES is written. Bytes outside the range are silently dropped. Nothing else changes.
- Reset: on a rising CLK edge with RST=1, every byte is set to mem[i] = i[7:0] (the diagnostic image).
  - RST takes priority over a simultaneous WE; that write is discarded.
- There is no reset-independent initial state requirement. Benches must apply RST before checking contents.

## Timing
- OUTPUT and FAULT are purely combinational from ADDR and the array, with zero-cycle latency. They settle within the same delta after an ADDR change.
- A write becomes visible on OUTPUT immediately after the CLK edge that performs it. Before that edge, OUTPUT shows the old data, including when ADDR overlaps WADDR.
- Reset takes effect at the first rising edge with RST=1. After that edge, OUTPUT reflects the diagnostic image, e.g. ADDR=0 gives 32'h0302_0100.
- Asserting RST mid-load aborts the load. Writes that completed on earlier edges are overwritten by the reset image.
- WE, WADDR, WDATA and WSTRB are sampled only at the rising edge. There is no handshake, and one write is accepted per cycle.

## Configuration
- Macro IMEM_MISALIGN_FAULT_EN.
- When defined:
  - A fetch with ADDR[1:0] != 2'b00 sets FAULT=1 and forces OUTPUT=32'h0000_0000.
  - The range check still applies, and FAULT is the OR of both conditions.
- When undefined (default), unaligned fetches return the four consecutive bytes as described, with FAULT=0 when in range.

## Test plan
- Reset then sweep: RST for 1 cycle, then ADDR=0,1,2,3,4,5 -> OUTPUT = 32'h03020100, 32'h04030201, 32'h05040302, 32'h06050403, 32'h07060504, 32'h08070605, with FAULT=0 (macro undefined).
- Full-word write: WE=1, WADDR=0, WDATA=32'h0000_0013, WSTRB=4'hF for one edge, then ADDR=0 -> 32'h00000013. Before the edge, the same ADDR returns 32'h03020100.
- Partial write: WADDR=8, WDATA=32'hAABBCCDD, WSTRB=4'b0101 after reset -> ADDR=8 reads 32'h0BBB09DD.
- Range boundary: DEPTH_BYTES=1024, ADDR=1020 -> 32'hFFFEFDFC with FAULT=0. ADDR=1021 and ADDR=64'hFFFF_FFFF_FFFF_FFFC -> OUTPUT=0 and FAULT=1.
- Reset vs write: RST=1 and WE=1 (WADDR=0, WDATA=32'hDEADBEEF) on the same edge -> ADDR=0 reads 32'h03020100.
- Macro defined: after reset, ADDR=4 -> 32'h07060504 with FAULT=0; ADDR=6 -> OUTPUT=0 with FAULT=1.
